// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: requester IDs, bus field widths, arbiter defaults
// and the round-robin pick helper.
package bus_arbiter_pkg;

  localparam int unsigned BUS_ADDR_W          = 32;
  localparam int unsigned BUS_DATA_W          = 32;
  localparam int unsigned REQ_ID_W            = 1;
  localparam int unsigned MAX_OUTSTANDING_DEF = 4;

  typedef enum logic [REQ_ID_W-1:0] {
    ID_M0 = 1'b0,
    ID_M1 = 1'b1
  } req_id_e;

  // Tie goes to the requester not granted most recently; a lone requester wins.
  function automatic req_id_e rr_pick(input logic act0, input logic act1,
                                      input req_id_e last);
    if (act0 && act1) return (last == ID_M1) ? ID_M0 : ID_M1;
    else if (act1)    return ID_M1;
    else              return ID_M0;
  endfunction

endpackage

// File: rtl/bus_arbiter_id_fifo.sv
// id_fifo: small synchronous FIFO of requester IDs.
// Ports: clk, rst_n (sync, active-low), push/push_id, pop/head,
//        full, empty, count (0..DEPTH).
module id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DW-1:0]          push_id,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  always_comb begin
    push_ok  = push & (~full | pop);
    pop_ok   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester round-robin arbiter onto one target with
// in-order read-response routing.
// Ports: clk, reset (sync, active-low); m0_/m1_ request inputs with req_ready,
//        res_valid/res_data back; s_ request outputs with s_req_ready and
//        s_res_valid/s_res_data from the target; outstanding read count;
//        sticky proto_err.
module bus_arbiter import bus_arbiter_pkg::*; #(
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned W               = BUS_DATA_W
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             m0_req_ready,
  input  logic                             m0_req_read,
  input  logic                             m0_req_write,
  input  logic [W-1:0]                     m0_req_address,
  input  logic [W-1:0]                     m0_req_data,
  output logic                             m0_res_valid,
  output logic [W-1:0]                     m0_res_data,
  output logic                             m1_req_ready,
  input  logic                             m1_req_read,
  input  logic                             m1_req_write,
  input  logic [W-1:0]                     m1_req_address,
  input  logic [W-1:0]                     m1_req_data,
  output logic                             m1_res_valid,
  output logic [W-1:0]                     m1_res_data,
  input  logic                             s_req_ready,
  output logic                             s_req_read,
  output logic                             s_req_write,
  output logic [W-1:0]                     s_req_address,
  output logic [W-1:0]                     s_req_data,
  input  logic                             s_res_valid,
  input  logic [W-1:0]                     s_res_data,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             proto_err
);

  req_id_e             last_q, last_d, gnt;
  logic                proto_err_q, proto_err_d;
  logic                act0, act1, any_act, g_rd, g_wr, accept, push, pop;
  logic                fifo_full, fifo_empty;
  logic [REQ_ID_W-1:0] head_id;

  id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .DW    (REQ_ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (push),
    .push_id (REQ_ID_W'(gnt)),
    .pop     (pop),
    .head    (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding)
  );

  // Grant and request forwarding; read+write together is forwarded as a write.
  always_comb begin
    act0    = m0_req_read | m0_req_write;
    act1    = m1_req_read | m1_req_write;
    any_act = (act0 | act1) & reset;
    gnt     = rr_pick(act0, act1, last_q);
    if (gnt == ID_M1) begin
      g_rd          = m1_req_read;
      g_wr          = m1_req_write;
      s_req_address = m1_req_address;
      s_req_data    = m1_req_data;
    end else begin
      g_rd          = m0_req_read;
      g_wr          = m0_req_write;
      s_req_address = m0_req_address;
      s_req_data    = m0_req_data;
    end
    s_req_write  = any_act & g_wr;
    s_req_read   = any_act & g_rd & ~g_wr & ~fifo_full;
    accept       = (s_req_read | s_req_write) & s_req_ready;
    m0_req_ready = accept & (gnt == ID_M0);
    m1_req_ready = accept & (gnt == ID_M1);
    push         = accept & s_req_read;
  end

  // Zero-latency response routing by the oldest outstanding ID.
  always_comb begin
    pop          = s_res_valid & ~fifo_empty & reset;
    m0_res_valid = pop & (head_id == REQ_ID_W'(ID_M0));
    m1_res_valid = pop & (head_id == REQ_ID_W'(ID_M1));
    m0_res_data  = m0_res_valid ? s_res_data : '0;
    m1_res_data  = m1_res_valid ? s_res_data : '0;
  end

  // Last grant moves only on accepted transfers; protocol errors are sticky.
  always_comb begin
    last_d      = accept ? gnt : last_q;
    proto_err_d = proto_err_q
                | (s_res_valid & fifo_empty)
                | (m0_req_read & m0_req_write)
                | (m1_req_read & m1_req_write);
  end

  assign proto_err = proto_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q      <= ID_M1;
      proto_err_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (MAX_OUTSTANDING=4, W=32).
module tb_bus_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned MO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         m0_req_ready, m0_req_read, m0_req_write, m0_res_valid;
  logic [W-1:0] m0_req_address, m0_req_data, m0_res_data;
  logic         m1_req_ready, m1_req_read, m1_req_write, m1_res_valid;
  logic [W-1:0] m1_req_address, m1_req_data, m1_res_data;
  logic         s_req_ready, s_req_read, s_req_write, s_res_valid;
  logic [W-1:0] s_req_address, s_req_data, s_res_data;
  logic [$clog2(MO):0] outstanding;
  logic         proto_err;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  bus_arbiter #(.MAX_OUTSTANDING(MO), .W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_req_ready   (m0_req_ready),
    .m0_req_read    (m0_req_read),
    .m0_req_write   (m0_req_write),
    .m0_req_address (m0_req_address),
    .m0_req_data    (m0_req_data),
    .m0_res_valid   (m0_res_valid),
    .m0_res_data    (m0_res_data),
    .m1_req_ready   (m1_req_ready),
    .m1_req_read    (m1_req_read),
    .m1_req_write   (m1_req_write),
    .m1_req_address (m1_req_address),
    .m1_req_data    (m1_req_data),
    .m1_res_valid   (m1_res_valid),
    .m1_res_data    (m1_res_data),
    .s_req_ready    (s_req_ready),
    .s_req_read     (s_req_read),
    .s_req_write    (s_req_write),
    .s_req_address  (s_req_address),
    .s_req_data     (s_req_data),
    .s_res_valid    (s_res_valid),
    .s_res_data     (s_res_data),
    .outstanding    (outstanding),
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    m0_req_read = 1'b0; m0_req_write = 1'b0; m0_req_address = 32'h100; m0_req_data = '0;
    m1_req_read = 1'b0; m1_req_write = 1'b0; m1_req_address = 32'h200; m1_req_data = '0;
    s_req_ready = 1'b1; s_res_valid = 1'b0; s_res_data = '0;

    // Reset: requests and responses are blocked
    m0_req_read = 1'b1;
    #1;
    chk("rst_s_req_read", 32'(s_req_read), 0);
    chk("rst_m0_req_ready", 32'(m0_req_ready), 0);
    tick(); tick();
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    s_res_valid = 1'b1;
    #1;
    chk("rst_m0_res_valid", 32'(m0_res_valid), 0);
    chk("rst_m1_res_valid", 32'(m1_res_valid), 0);
    tick();
    chk("rst_proto_err_resp", 32'(proto_err), 0);
    s_res_valid = 1'b0;

    // Alternating reads, target answers two cycles after acceptance
    reset = 1'b1; m1_req_read = 1'b1;
    #1;
    chk("alt_a_m0_ready", 32'(m0_req_ready), 1);
    chk("alt_a_m1_ready", 32'(m1_req_ready), 0);
    chk("alt_a_addr", s_req_address, 32'h100);
    tick();
    chk("alt_a_outst", 32'(outstanding), 1);
    chk("alt_b_m1_ready", 32'(m1_req_ready), 1);
    chk("alt_b_addr", s_req_address, 32'h200);
    tick();
    chk("alt_b_outst", 32'(outstanding), 2);
    s_res_valid = 1'b1; s_res_data = 32'hAAAA0000;
    #1;
    chk("alt_c_m0_ready", 32'(m0_req_ready), 1);
    chk("alt_c_m0_res_valid", 32'(m0_res_valid), 1);
    chk("alt_c_m0_res_data", m0_res_data, 32'hAAAA0000);
    chk("alt_c_m1_res_valid", 32'(m1_res_valid), 0);
    chk("alt_c_m1_res_data", m1_res_data, 0);
    tick();
    chk("alt_c_outst", 32'(outstanding), 2);
    s_res_data = 32'hBBBB0001;
    #1;
    chk("alt_d_m1_ready", 32'(m1_req_ready), 1);
    chk("alt_d_m1_res_valid", 32'(m1_res_valid), 1);
    chk("alt_d_m1_res_data", m1_res_data, 32'hBBBB0001);
    chk("alt_d_m0_res_data", m0_res_data, 0);
    tick();
    chk("alt_d_outst", 32'(outstanding), 2);
    m0_req_read = 1'b0; m1_req_read = 1'b0; s_res_data = 32'hAAAA0002;
    #1;
    chk("alt_e_idle_read", 32'(s_req_read), 0);
    chk("alt_e_m0_res_valid", 32'(m0_res_valid), 1);
    tick();
    chk("alt_e_outst", 32'(outstanding), 1);
    s_res_data = 32'hBBBB0003;
    #1;
    chk("alt_f_m1_res_valid", 32'(m1_res_valid), 1);
    chk("alt_f_m1_res_data", m1_res_data, 32'hBBBB0003);
    tick();
    chk("alt_f_outst", 32'(outstanding), 0);
    s_res_valid = 1'b0;

    // Stalled target: grant holds on m0 (last grant was m1)
    s_req_ready = 1'b0; m0_req_read = 1'b1; m1_req_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_addr", s_req_address, 32'h100);
      chk("stall_m0_ready", 32'(m0_req_ready), 0);
      tick();
    end
    chk("stall_outst", 32'(outstanding), 0);
    s_req_ready = 1'b1;
    #1;
    chk("stall_rel_m0_ready", 32'(m0_req_ready), 1);
    chk("stall_rel_m1_ready", 32'(m1_req_ready), 0);
    tick();
    chk("stall_rel_outst", 32'(outstanding), 1);
    m0_req_read = 1'b0; m1_req_read = 1'b0; s_res_valid = 1'b1; s_res_data = 32'h55;
    #1;
    chk("stall_resp_m0", 32'(m0_res_valid), 1);
    tick();
    chk("stall_resp_outst", 32'(outstanding), 0);
    s_res_valid = 1'b0;

    // Outstanding limit: four reads accepted, fifth stalls, write still passes
    m0_req_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lim_m0_ready", 32'(m0_req_ready), 1);
      tick();
      chk("lim_outst", 32'(outstanding), 32'(i + 1));
    end
    #1;
    chk("lim5_m0_ready", 32'(m0_req_ready), 0);
    chk("lim5_s_req_read", 32'(s_req_read), 0);
    tick();
    chk("lim5_outst", 32'(outstanding), 4);
    m1_req_write = 1'b1; m1_req_address = 32'h300; m1_req_data = 32'hDEAD;
    #1;
    chk("lim_wr_s_write", 32'(s_req_write), 1);
    chk("lim_wr_m1_ready", 32'(m1_req_ready), 1);
    chk("lim_wr_data", s_req_data, 32'hDEAD);
    tick();
    chk("lim_wr_outst", 32'(outstanding), 4);
    m1_req_write = 1'b0; m1_req_address = 32'h200;
    #1;
    chk("lim_after_wr_m0_ready", 32'(m0_req_ready), 0);
    m0_req_read = 1'b0; s_res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_res_data = 32'(i);
      #1;
      chk("lim_drain_m0", 32'(m0_res_valid), 1);
      tick();
    end
    s_res_valid = 1'b0;
    chk("lim_drain_outst", 32'(outstanding), 0);

    // Read push and response pop in the same cycle
    m1_req_read = 1'b1;
    #1;
    chk("same_m1_ready", 32'(m1_req_ready), 1);
    tick();
    chk("same_outst1", 32'(outstanding), 1);
    m1_req_read = 1'b0; m0_req_read = 1'b1; s_res_valid = 1'b1; s_res_data = 32'h1234;
    #1;
    chk("same_m0_ready", 32'(m0_req_ready), 1);
    chk("same_m1_res_valid", 32'(m1_res_valid), 1);
    chk("same_m1_res_data", m1_res_data, 32'h1234);
    chk("same_m0_res_valid", 32'(m0_res_valid), 0);
    tick();
    chk("same_outst_hold", 32'(outstanding), 1);
    s_res_valid = 1'b0;
    tick(); tick();
    m0_req_read = 1'b0;
    chk("pre_rst_outst", 32'(outstanding), 3);
    chk("pre_rst_proto_err", 32'(proto_err), 0);

    // Mid-operation reset discards IDs; the next tie goes to m0
    reset = 1'b0; m0_req_read = 1'b1; m1_req_read = 1'b1;
    #1;
    chk("mid_rst_s_read", 32'(s_req_read), 0);
    chk("mid_rst_m1_ready", 32'(m1_req_ready), 0);
    tick();
    chk("mid_rst_outst", 32'(outstanding), 0);
    reset = 1'b1;
    #1;
    chk("post_rst_m0_ready", 32'(m0_req_ready), 1);
    chk("post_rst_m1_ready", 32'(m1_req_ready), 0);
    tick();
    chk("post_rst_outst", 32'(outstanding), 1);
    m0_req_read = 1'b0; m1_req_read = 1'b0; s_res_valid = 1'b1;
    #1;
    chk("post_rst_resp_m0", 32'(m0_res_valid), 1);
    tick();
    chk("post_rst_resp_outst", 32'(outstanding), 0);

    // Response with empty FIFO is dropped and sets the sticky error
    s_res_data = 32'h77;
    #1;
    chk("orphan_m0_valid", 32'(m0_res_valid), 0);
    chk("orphan_m1_valid", 32'(m1_res_valid), 0);
    chk("orphan_m0_data", m0_res_data, 0);
    tick();
    s_res_valid = 1'b0;
    chk("orphan_proto_err", 32'(proto_err), 1);
    tick(); tick();
    chk("orphan_proto_sticky", 32'(proto_err), 1);
    chk("orphan_outst", 32'(outstanding), 0);

    // Read and write together: forwarded as a write, no ID pushed
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rw_clear_proto_err", 32'(proto_err), 0);
    m0_req_read = 1'b1; m0_req_write = 1'b1; m0_req_address = 32'h400;
    #1;
    chk("rw_s_write", 32'(s_req_write), 1);
    chk("rw_s_read", 32'(s_req_read), 0);
    chk("rw_m0_ready", 32'(m0_req_ready), 1);
    tick();
    m0_req_read = 1'b0; m0_req_write = 1'b0;
    chk("rw_outst", 32'(outstanding), 0);
    chk("rw_proto_err", 32'(proto_err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4: maximum reads issued to the target and not yet answered; power of two, 2..16.
REQ-002 Parameter W, default 32: address and data width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-005 m0_req_ready / m1_req_ready  output  1  requester n's request accepted this cycle.
REQ-006 m0_req_read / m1_req_read  input  1  requester n requests a read.
REQ-007 m0_req_write / m1_req_write  input  1  requester n requests a write.
REQ-008 m0_req_address / m1_req_address  input  W  request address.
REQ-009 m0_req_data / m1_req_data  input  W  write data.
REQ-010 m0_res_valid / m1_res_valid  output  1  read data returned to requester n.
REQ-011 m0_res_data / m1_res_data  output  W  read data, valid with res_valid.
REQ-012 s_req_ready  input  1  target accepts the presented request.
REQ-013 s_req_read, s_req_write  output  1  forwarded request strobes.
REQ-014 s_req_address, s_req_data  output  W  forwarded address and write data.
REQ-015 s_res_valid, s_res_data  input  1, W  in-order read response from the target.
REQ-016 outstanding  output  clog2(MAX_OUTSTANDING)+1  number of reads in flight.
REQ-017 proto_err  output  1  sticky protocol-error flag.

Function
REQ-018 A requester is active when read or write is high; it SHALL hold its request stable until its req_ready is high.
REQ-019 Grant SHALL be combinational round-robin: if both requesters are active, the one not granted most recently wins; if one is active, it wins.
REQ-020 s_req_* SHALL mux the granted requester's fields; with no active requester, s_req_read and s_req_write SHALL be 0.
REQ-021 A transfer is accepted when s_req_ready is high and the granted request is forwarded; only the granted requester's req_ready SHALL be high, equal to s_req_ready.
REQ-022 A granted read SHALL be suppressed when outstanding == MAX_OUTSTANDING (s_req_read=0, req_ready=0); a granted write proceeds regardless.
REQ-023 The last-grant register SHALL update only on an accepted transfer, never on a stalled one.
REQ-024 Each accepted read SHALL push the requester ID into a FIFO of depth MAX_OUTSTANDING; writes push nothing.
REQ-025 On s_res_valid, the head ID SHALL be popped; the matching mN_res_valid is high that same cycle with mN_res_data = s_res_data (zero latency); the other res_valid is 0.
REQ-026 A simultaneous push and pop SHALL leave outstanding unchanged; a response and a read from the same requester in one cycle are both legal.
REQ-027 s_res_valid with an empty FIFO SHALL be dropped (no res_valid) and SHALL set proto_err.
REQ-028 A requester asserting read and write together SHALL set proto_err; the request is forwarded as a write and no ID is pushed.
REQ-029 res_data of an unselected requester SHALL be 0.

Reset
REQ-030 While reset is low: FIFO empty, outstanding=0, proto_err=0, last grant = m1 (so m0 wins the first tie), all res_valid=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight IDs; responses arriving after reset are treated per REQ-027.
REQ-032 s_req_read, s_req_write and all req_ready SHALL be 0 while reset is low.

Structure
REQ-033 Requester-ID width and the MAX_OUTSTANDING default SHALL live in the shared bus package alongside the bus request/response field widths.
REQ-034 The ID FIFO SHALL be one sub-module, id_fifo (push, pop, full, empty, count), reusable elsewhere in the SoC.

Verification
REQ-035 Both requesters read continuously, s_req_ready=1, target answers 2 cycles later -> grants alternate m0,m1,m0...; each requester receives only its own data.
REQ-036 m0 reads addr 0x100 four times, target withholds responses, MAX_OUTSTANDING=4 -> 5th read stalls, outstanding=4; a write from m1 still completes.
REQ-037 m0 read accepted in the same cycle as the response for m1's earlier read -> m1_res_valid=1 and outstanding unchanged.
REQ-038 s_res_valid pulsed with FIFO empty -> no res_valid and proto_err=1 until reset.
REQ-039 s_req_ready held 0 for 5 cycles while both requesters are active -> the grant stays on the same requester and last grant is unchanged.
REQ-040 Reset asserted with 3 reads outstanding -> outstanding=0 on the next edge; a subsequent tie goes to m0.
